// File: rtl/clause_slice_evaluator.sv
// clause_slice_evaluator
//   Consumer end of the static clause memory. Snapshots a variable assignment on start, then
//   evaluates the clause slice stream row by row until NUM_ROWS valid slices have been seen.
//   Each pass reports SAT/UNSAT, the number of unsat clauses and the lowest unsat clause index.
//
// Optional feature macro: CLAUSE_UNSAT_MASK_EN (adds the unsat_mask output).
//
// Ports
//   clk          clock
//   rst_n        asynchronous active-low reset
//   start        begin a pass (accepted in IDLE/DONE); snapshots assign_vec
//   assign_vec   variable values, bit v = value of variable v
//   slice_valid  slice_in/slice_row valid this cycle
//   slice_in     NUM_CLAUSES_PER_CYCLE clauses, lane c at [c*CL_W +: CL_W]
//   slice_row    row index of slice_in
//   busy         pass in progress
//   done         one-cycle pulse when results update
//   sat          all clauses satisfied in the last completed pass
//   unsat_count  number of unsat clauses in the last completed pass
//   first_unsat  lowest global index of an unsat clause, 0 when sat
//   unsat_mask   per-clause unsat flags of the last completed pass (CLAUSE_UNSAT_MASK_EN only)
module clause_slice_evaluator #(
   parameter int unsigned NUM_CLAUSES           = 64,
   parameter int unsigned VAR_ID_BITS           = 8,
   parameter int unsigned NUM_CLAUSES_PER_CYCLE = 16,
   parameter int unsigned NUM_VARS_PER_CLAUSE   = 3,
   localparam int unsigned NUM_VARS = 2 ** VAR_ID_BITS,
   localparam int unsigned LIT_W    = VAR_ID_BITS + 1,
   localparam int unsigned CL_W     = LIT_W * NUM_VARS_PER_CLAUSE,
   localparam int unsigned SLICE_W  = CL_W * NUM_CLAUSES_PER_CYCLE,
   localparam int unsigned NUM_ROWS = NUM_CLAUSES / NUM_CLAUSES_PER_CYCLE,
   localparam int unsigned PTR_BITS = $clog2(NUM_ROWS),
   localparam int unsigned IDX_BITS = $clog2(NUM_CLAUSES),
   localparam int unsigned CNT_W    = $clog2(NUM_CLAUSES + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [NUM_VARS-1:0] assign_vec,
   input  logic                slice_valid,
   input  logic [SLICE_W-1:0]  slice_in,
   input  logic [PTR_BITS-1:0] slice_row,
   output logic                busy,
   output logic                done,
   output logic                sat,
   output logic [CNT_W-1:0]    unsat_count,
`ifdef CLAUSE_UNSAT_MASK_EN
   output logic [NUM_CLAUSES-1:0] unsat_mask,
`endif
   output logic [IDX_BITS-1:0] first_unsat
);

   localparam int unsigned ROW_CNT_W = PTR_BITS + 1;

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e                 state_q, state_d;
   logic [NUM_VARS-1:0]    snap_q, snap_d;
   logic [ROW_CNT_W-1:0]   rows_q, rows_d;
   logic [CNT_W-1:0]       acc_cnt_q, acc_cnt_d;
   logic [IDX_BITS-1:0]    acc_first_q, acc_first_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   sat_q, sat_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [IDX_BITS-1:0]    first_q, first_d;
`ifdef CLAUSE_UNSAT_MASK_EN
   logic [NUM_CLAUSES-1:0] shadow_q, shadow_d;
   logic [NUM_CLAUSES-1:0] mask_q, mask_d;
`endif

   // Per-slice evaluation against the snapshot
   logic [NUM_CLAUSES_PER_CYCLE-1:0] lane_unsat;
   logic [CNT_W-1:0]                 slice_cnt;
   logic [IDX_BITS-1:0]              slice_first;
   logic [IDX_BITS-1:0]              slice_base;
   logic [LIT_W-1:0]                 lit;
   logic                             cl_sat;

   always_comb begin
      lane_unsat  = '0;
      slice_cnt   = '0;
      // All-ones is the neutral element of the running minimum
      slice_first = '1;
      lit         = '0;
      cl_sat      = 1'b0;
      slice_base  = IDX_BITS'(slice_row) * IDX_BITS'(NUM_CLAUSES_PER_CYCLE);
      for (int c = 0; c < int'(NUM_CLAUSES_PER_CYCLE); c++) begin
         cl_sat = 1'b0;
         for (int k = 0; k < int'(NUM_VARS_PER_CLAUSE); k++) begin
            lit    = slice_in[c*CL_W + k*LIT_W +: LIT_W];
            cl_sat = cl_sat | (snap_q[lit[LIT_W-1:1]] ^ lit[0]);
         end
         lane_unsat[c] = ~cl_sat;
         slice_cnt     = slice_cnt + CNT_W'(lane_unsat[c]);
      end
      // Walk downwards so the lowest unsat lane wins
      for (int c = int'(NUM_CLAUSES_PER_CYCLE) - 1; c >= 0; c--) begin
         if (lane_unsat[c]) slice_first = slice_base + IDX_BITS'(c);
      end
   end

   always_comb begin
      state_d     = state_q;
      snap_d      = snap_q;
      rows_d      = rows_q;
      acc_cnt_d   = acc_cnt_q;
      acc_first_d = acc_first_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      sat_d       = sat_q;
      cnt_d       = cnt_q;
      first_d     = first_q;
`ifdef CLAUSE_UNSAT_MASK_EN
      shadow_d    = shadow_q;
      mask_d      = mask_q;
`endif
      case (state_q)
         StIdle, StDone: begin
            state_d = StIdle;
            if (start) begin
               snap_d      = assign_vec;
               rows_d      = '0;
               acc_cnt_d   = '0;
               acc_first_d = '1;
               busy_d      = 1'b1;
`ifdef CLAUSE_UNSAT_MASK_EN
               shadow_d    = '0;
`endif
               state_d     = StScan;
            end
         end
         StScan: begin
            if (slice_valid) begin
               rows_d      = rows_q + ROW_CNT_W'(1);
               acc_cnt_d   = acc_cnt_q + slice_cnt;
               acc_first_d = (slice_first < acc_first_q) ? slice_first : acc_first_q;
`ifdef CLAUSE_UNSAT_MASK_EN
               shadow_d    = shadow_q | (NUM_CLAUSES'(lane_unsat) << slice_base);
`endif
               // Final slice: publish totals including this slice
               if (rows_q == ROW_CNT_W'(NUM_ROWS - 1)) begin
                  cnt_d   = acc_cnt_d;
                  sat_d   = (acc_cnt_d == '0);
                  first_d = (acc_cnt_d == '0) ? '0 : acc_first_d;
`ifdef CLAUSE_UNSAT_MASK_EN
                  mask_d  = shadow_d;
`endif
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = StDone;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         snap_q      <= '0;
         rows_q      <= '0;
         acc_cnt_q   <= '0;
         acc_first_q <= '1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sat_q       <= 1'b0;
         cnt_q       <= '0;
         first_q     <= '0;
`ifdef CLAUSE_UNSAT_MASK_EN
         shadow_q    <= '0;
         mask_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         snap_q      <= snap_d;
         rows_q      <= rows_d;
         acc_cnt_q   <= acc_cnt_d;
         acc_first_q <= acc_first_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         sat_q       <= sat_d;
         cnt_q       <= cnt_d;
         first_q     <= first_d;
`ifdef CLAUSE_UNSAT_MASK_EN
         shadow_q    <= shadow_d;
         mask_q      <= mask_d;
`endif
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign sat         = sat_q;
   assign unsat_count = cnt_q;
   assign first_unsat = first_q;
`ifdef CLAUSE_UNSAT_MASK_EN
   assign unsat_mask  = mask_q;
`endif

endmodule
